interval_timer_ctrl: RTL

Sequencer for an 8-bit loadable up-counter datapath. It configures the period and mode, then drives the counter's load and enable controls. Its FSM starts, pauses, stops and restarts counting. It emits a one-cycle tick at terminal count, in one-shot or auto-reload mode. It sits between a register-write interface and the timing consumers (strobes, timeouts).

---
 rtl/interval_timer_pkg.sv | 17 +
 rtl/interval_timer_ctrl_cnt_dp.sv | 36 +++
 rtl/interval_timer_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/interval_timer_pkg.sv
// Shared constants for the interval timer: FSM state encoding, mode encoding
// and default sizing.
package interval_timer_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic MODE_ONESHOT    = 1'b0;
    localparam logic MODE_AUTORELOAD = 1'b1;

    localparam int         DEFAULT_WIDTH_C    = 8;
    localparam logic [7:0] DEFAULT_PERIOD_C   = 8'hFF;
    localparam int         DEFAULT_PRESCALE_C = 4;

endpackage

// File: rtl/interval_timer_ctrl_cnt_dp.sv
// Counter datapath: WIDTH-bit register with clear, load and +1 enable, plus
// the terminal-count equality compare.
module timer_cnt_dp
    import interval_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH_C
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] count,
    output logic             at_term
);

    logic [WIDTH-1:0] count_r;

    // Count register; clear beats load beats increment, carry-out is discarded.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (ld) begin
            count_r <= ld_val;
        end else if (en) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count   = count_r;
    assign at_term = (count_r == term_val);

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer sequencer: config registers, start/pause/stop FSM and tick.
// Optional prescaler enabled by defining INTERVAL_TIMER_PRESCALE_EN.
module interval_timer_ctrl
    import interval_timer_pkg::*;
#(
    parameter int               WIDTH          = DEFAULT_WIDTH_C,
    parameter logic [WIDTH-1:0] DEFAULT_PERIOD = DEFAULT_PERIOD_C
`ifdef INTERVAL_TIMER_PRESCALE_EN
    ,
    parameter int               PRESCALE       = DEFAULT_PRESCALE_C
`endif
) (
    input  logic             clk,
    input  logic             res,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic [1:0]       state
);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             tick_r;
    logic             tick_nxt_s;
    logic             busy_r;
    logic [WIDTH-1:0] period_r;
    logic             mode_r;
    logic             cfg_ld_s;
    logic             clr_s;
    logic             ld_s;
    logic             en_s;
    logic             step_s;
    logic             at_term_s;

`ifdef INTERVAL_TIMER_PRESCALE_EN
    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PSC_W-1:0] psc_r;
    logic             psc_clr_s;
    logic             psc_adv_s;

    assign step_s    = (psc_r == PSC_W'(PRESCALE - 1));
    assign psc_clr_s = stop | start | (state_nxt_s == ST_IDLE) | (state_nxt_s == ST_DONE);
    assign psc_adv_s = (state_r == ST_RUN) & ~pause;

    // Prescaler: wraps on the step cycle, frozen while paused.
    always_ff @(posedge clk) begin
        if (res || psc_clr_s) begin
            psc_r <= {PSC_W{1'b0}};
        end else if (psc_adv_s) begin
            psc_r <= step_s ? {PSC_W{1'b0}} : psc_r + PSC_W'(1);
        end else begin
            psc_r <= psc_r;
        end
    end
`else
    assign step_s = 1'b1;
`endif

    // Next-state and datapath control, priority stop > start > pause > cfg_we.
    always_comb begin
        state_nxt_s = state_r;
        tick_nxt_s  = 1'b0;
        cfg_ld_s    = 1'b0;
        clr_s       = 1'b0;
        ld_s        = 1'b0;
        en_s        = 1'b0;
        if (stop) begin
            clr_s       = 1'b1;
            state_nxt_s = ST_IDLE;
        end else if (start) begin
            ld_s        = 1'b1;
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cfg_ld_s = cfg_we;
                end
                ST_RUN: begin
                    if (pause) begin
                        state_nxt_s = ST_PAUSED;
                    end else if (step_s && at_term_s) begin
                        tick_nxt_s = 1'b1;
                        if (mode_r == MODE_AUTORELOAD) begin
                            ld_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_DONE;
                        end
                    end else if (step_s) begin
                        en_s = 1'b1;
                    end else begin
                        en_s = 1'b0;
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_PAUSED;
                    end
                end
                ST_DONE: begin
                    cfg_ld_s = cfg_we;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM, tick, busy and configuration registers.
    always_ff @(posedge clk) begin
        if (res) begin
            state_r  <= ST_IDLE;
            tick_r   <= 1'b0;
            busy_r   <= 1'b0;
            period_r <= DEFAULT_PERIOD;
            mode_r   <= MODE_ONESHOT;
        end else begin
            state_r <= state_nxt_s;
            tick_r  <= tick_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN) | (state_nxt_s == ST_PAUSED);
            if (cfg_ld_s) begin
                period_r <= cfg_period;
                mode_r   <= cfg_mode;
            end else begin
                period_r <= period_r;
                mode_r   <= mode_r;
            end
        end
    end

    timer_cnt_dp #(
        .WIDTH(WIDTH)
    ) u_cnt_dp (
        .clk     (clk),
        .clr     (res | clr_s),
        .ld      (ld_s),
        .ld_val  ({WIDTH{1'b0}}),
        .en      (en_s),
        .term_val(period_r),
        .count   (count),
        .at_term (at_term_s)
    );

    assign tick  = tick_r;
    assign busy  = busy_r;
    assign state = state_r;

endmodule
